complete_stage_rr: RTL

// - Parametrised complete/writeback arbiter: N_FU functional units compete for N_CDB common-data-bus lanes.
// - Grants up to N_CDB finishing FUs per cycle, round-robin or fixed priority.
// - Registers winners onto the CDB: PR tag + value to regfile/RS; rob_entry, branch info, halt to ROB.
// - Per-FU valid/ready handshake replaces the fu_c_stall mask; squash drops work on mispredict.

---
 rtl/complete_stage_rr_pkg.sv | 50 +++++
 rtl/complete_stage_rr_multi_grant.sv | 48 ++++
 rtl/complete_stage_rr.sv | 136 +++++++++++++
 3 files changed

// File: rtl/complete_stage_rr_pkg.sv
// ---------------------------------------------------------------------------
// complete_stage_rr_pkg
// Shared types and widths for the complete/writeback stage.
//   XLEN  : datapath / PC width
//   PR_W  : physical-register tag width (tag 0 means "no register writeback")
//   ROB_W : reorder-buffer index width
//   FU_COMPLETE_PACKET : what a functional unit presents when it finishes
//   CDB_LANE_PACKET    : what one common-data-bus lane carries after the arbiter
// ---------------------------------------------------------------------------
package complete_stage_rr_pkg;

    localparam int XLEN  = 32;
    localparam int PR_W  = 6;
    localparam int ROB_W = 5;

    typedef struct packed {
        logic [PR_W-1:0]  dest_pr;
        logic [XLEN-1:0]  value;
        logic [ROB_W-1:0] rob_entry;
        logic             if_take_branch;
        logic [XLEN-1:0]  target_pc;
        logic             halt;
    } FU_COMPLETE_PACKET;

    typedef struct packed {
        logic             valid;
        logic [PR_W-1:0]  cdb_t;
        logic [XLEN-1:0]  wb_value;
        logic [ROB_W-1:0] complete_entry;
        logic             precise_state_valid;
        logic [XLEN-1:0]  target_pc;
        logic             halt;
    } CDB_LANE_PACKET;

    // Convert a winning FU packet into a lane bundle; the redirect PC is only
    // meaningful for a taken branch, so it is forced to zero otherwise.
    function automatic CDB_LANE_PACKET lane_from_fu(input FU_COMPLETE_PACKET pkt,
                                                    input logic              sel);
        CDB_LANE_PACKET lane;
        lane.valid               = sel;
        lane.cdb_t               = pkt.dest_pr;
        lane.wb_value            = pkt.value;
        lane.complete_entry      = pkt.rob_entry;
        lane.precise_state_valid = pkt.if_take_branch;
        lane.target_pc           = pkt.if_take_branch ? pkt.target_pc : {XLEN{1'b0}};
        lane.halt                = pkt.halt;
        return lane;
    endfunction

endpackage

// File: rtl/complete_stage_rr_multi_grant.sv
// ---------------------------------------------------------------------------
// rr_multi_grant
// Picks up to K requesters per cycle, scanning from a start index upward
// (modulo N). The k-th requester found is reported on lane_sel[k], so lanes
// fill from 0 upward with no holes.
//   req      [N]     : request vector
//   start    [PTR_W] : first index to consider
//   grant    [N]     : union of all lane selects
//   lane_sel [K][N]  : one-hot (or zero) selection per lane
// ---------------------------------------------------------------------------
module rr_multi_grant
    import complete_stage_rr_pkg::*;
#(
    parameter int N     = 8,
    parameter int K     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [PTR_W-1:0]    start,
    output logic [N-1:0]        grant,
    output logic [K-1:0][N-1:0] lane_sel
);

    // Rotating priority select: prefer the lowest request at or above the
    // start index; if there is none, wrap and take the lowest request overall.
    function automatic logic [N-1:0] pick_first(input logic [N-1:0]     r,
                                                input logic [PTR_W-1:0] s);
        logic [N-1:0] upper;
        logic [N-1:0] src;
        for (int i = 0; i < N; i++) begin
            upper[i] = r[i] && (i >= int'(s));
        end
        src = (|upper) ? upper : r;
        return src & (~src + N'(1'b1));
    endfunction

    // K chained stages: each stage removes its winner from the pool it hands on.
    always_comb begin
        logic [N-1:0] remain;
        remain = req;
        for (int k = 0; k < K; k++) begin
            lane_sel[k] = pick_first(remain, start);
            remain      = remain & ~lane_sel[k];
        end
        grant = req & ~remain;
    end

endmodule

// File: rtl/complete_stage_rr.sv
// ---------------------------------------------------------------------------
// complete_stage_rr
// Complete/writeback arbiter: N_FU finishing functional units compete for
// N_CDB common-data-bus lanes. Winners are registered onto the CDB one cycle
// after the grant.
//   clock, reset (async, active-low), squash (drop this cycle's completions)
//   fu_valid/fu_c_in/fu_ready : per-FU valid/ready handshake (ready is combinational)
//   complete_valid, cdb_t, wb_value, complete_entry, precise_state_valid,
//   target_pc, halt           : registered per-lane CDB/ROB outputs
// Parameters: N_FU, N_CDB, RR_MODE (1 = round-robin, 0 = fixed, FU0 highest)
// ---------------------------------------------------------------------------
module complete_stage_rr
    import complete_stage_rr_pkg::*;
#(
    parameter int N_FU    = 8,
    parameter int N_CDB   = 3,
    parameter int RR_MODE = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [N_FU-1:0]               fu_valid,
    input  FU_COMPLETE_PACKET [N_FU-1:0]  fu_c_in,
    output logic [N_FU-1:0]               fu_ready,
    output logic [N_CDB-1:0]              complete_valid,
    output logic [N_CDB-1:0][PR_W-1:0]    cdb_t,
    output logic [N_CDB-1:0][XLEN-1:0]    wb_value,
    output logic [N_CDB-1:0][ROB_W-1:0]   complete_entry,
    output logic [N_CDB-1:0]              precise_state_valid,
    output logic [N_CDB-1:0][XLEN-1:0]    target_pc,
    output logic [N_CDB-1:0]              halt
);

    localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int PKT_W = $bits(FU_COMPLETE_PACKET);

    logic [PTR_W-1:0]               rr_ptr_r;
    logic [PTR_W-1:0]               rr_ptr_next_s;
    logic [PTR_W-1:0]               start_s;
    logic [PTR_W-1:0]               last_idx_s;
    logic [N_FU-1:0]                req_s;
    logic [N_FU-1:0]                grant_s;
    logic [N_FU-1:0]                last_sel_s;
    logic [N_CDB-1:0][N_FU-1:0]     lane_sel_s;
    FU_COMPLETE_PACKET [N_CDB-1:0]  win_pkt_s;
    CDB_LANE_PACKET [N_CDB-1:0]     lane_next_s;
    CDB_LANE_PACKET [N_CDB-1:0]     lane_r;

    // Requests are withheld during reset and squash, so nothing is granted,
    // nothing is registered and the pointer cannot move.
    always_comb begin
        if (reset && !squash) begin
            req_s = fu_valid;
        end else begin
            req_s = '0;
        end
    end

    // Scan start: rotating pointer in round-robin mode, FU0 in fixed mode.
    always_comb begin
        if (RR_MODE != 0) begin
            start_s = rr_ptr_r;
        end else begin
            start_s = '0;
        end
    end

    rr_multi_grant #(
        .N     (N_FU),
        .K     (N_CDB),
        .PTR_W (PTR_W)
    ) u_grant (
        .req      (req_s),
        .start    (start_s),
        .grant    (grant_s),
        .lane_sel (lane_sel_s)
    );

    assign fu_ready = grant_s;

    // One-hot AND-OR lane muxes; an empty select yields an all-zero lane.
    always_comb begin
        for (int k = 0; k < N_CDB; k++) begin
            win_pkt_s[k] = '0;
            for (int i = 0; i < N_FU; i++) begin
                win_pkt_s[k] = win_pkt_s[k] | (fu_c_in[i] & {PKT_W{lane_sel_s[k][i]}});
            end
            lane_next_s[k] = lane_from_fu(win_pkt_s[k], |lane_sel_s[k]);
        end
    end

    // Next pointer: one past the FU taken by the highest filled lane, which is
    // the last one reached by the scan.
    always_comb begin
        last_sel_s = '0;
        for (int k = 0; k < N_CDB; k++) begin
            last_sel_s = (|lane_sel_s[k]) ? lane_sel_s[k] : last_sel_s;
        end
        last_idx_s = '0;
        for (int i = 0; i < N_FU; i++) begin
            last_idx_s = last_idx_s | (last_sel_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
        end
        if (!(|grant_s)) begin
            rr_ptr_next_s = rr_ptr_r;
        end else if (last_idx_s == PTR_W'(N_FU - 1)) begin
            rr_ptr_next_s = '0;
        end else begin
            rr_ptr_next_s = last_idx_s + PTR_W'(1);
        end
    end

    // Pointer and CDB output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= '0;
            lane_r   <= '0;
        end else begin
            rr_ptr_r <= rr_ptr_next_s;
            lane_r   <= lane_next_s;
        end
    end

    // Unpack the registered lanes onto the output ports.
    always_comb begin
        for (int k = 0; k < N_CDB; k++) begin
            complete_valid[k]      = lane_r[k].valid;
            cdb_t[k]               = lane_r[k].cdb_t;
            wb_value[k]            = lane_r[k].wb_value;
            complete_entry[k]      = lane_r[k].complete_entry;
            precise_state_valid[k] = lane_r[k].precise_state_valid;
            target_pc[k]           = lane_r[k].target_pc;
            halt[k]                = lane_r[k].halt;
        end
    end

endmodule
